// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial add sequencer.
// Holds the controller state encoding and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bit_counter.sv
// Purpose: CNT_W-bit up-counter with sync clear, enable and terminal-count flag at WIDTH-1.
// Latency: count updates on the edge after en; tc is decoded from the registered count.
// Backpressure: none; clr has priority over en, and the count wraps to 0 after WIDTH-1.
module bit_counter #(
    parameter int  WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] q,
    output logic             tc
);

    assign tc = (q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= tc ? '0 : q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose: Moore sequencer for the bit-serial adder: one load cycle, WIDTH shift cycles, one done pulse.
// Latency: start at edge t -> ld in t+1, sh in t+2..t+WIDTH+1, done in t+WIDTH+2.
// Backpressure: none; start is ignored (not queued) unless IDLE, abort honoured in LOAD/SHIFT.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             ld,
    output logic             sh,
    output logic             carry_clr,
    output logic             carry_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    state_t state;
    state_t state_nxt;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_tc;

    // Counter only runs in SHIFT; any exit from SHIFT (abort, reset) leaves it at 0.
    assign cnt_en  = (state == SHIFT);
    assign cnt_clr = reset || (state != SHIFT) || abort;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk (clk),
        .clr (cnt_clr),
        .en  (cnt_en),
        .q   (bit_cnt),
        .tc  (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = abort ? IDLE : SHIFT;
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt_tc) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld        = 1'b0;
        sh        = 1'b0;
        carry_clr = 1'b0;
        carry_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            LOAD: begin
                ld        = 1'b1;
                carry_clr = 1'b1;
                busy      = 1'b1;
            end
            SHIFT: begin
                sh        = 1'b1;
                carry_en  = 1'b1;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: drives random operations, models the serial datapath around the
// controller, and scoreboards per-cycle strobes plus the final sum on each done pulse.
module tb_serial_add_ctrl;

    localparam int W  = 32;
    localparam int CW = $clog2(W);
    localparam int PERIOD = W + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          ld;
    logic          sh;
    logic          carry_clr;
    logic          carry_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] bit_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    logic [31:0]   opa, opb;
    logic [31:0]   ra, rb, rs;
    logic          cf;

    // expected {ld,sh,carry_clr,carry_en,busy,done,bit_cnt} per cycle; absent means all zero
    logic [5+CW:0] exp_vec [int];
    logic [32:0]   sb_q [$];

    serial_add_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .ld        (ld),
        .sh        (sh),
        .carry_clr (carry_clr),
        .carry_en  (carry_en),
        .busy      (busy),
        .done      (done),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand shift registers, result register and carry flop steered by the controller.
    always @(posedge clk) begin
        if (ld) begin
            ra <= opa;
            rb <= opb;
        end else if (sh) begin
            ra <= ra >> 1;
            rb <= rb >> 1;
            rs <= {ra[0] ^ rb[0] ^ cf, rs[31:1]};
        end
        if (carry_clr)     cf <= 1'b0;
        else if (carry_en) cf <= (ra[0] & rb[0]) | (ra[0] & cf) | (rb[0] & cf);
    end

    always @(negedge clk) begin : monitor
        logic [5+CW:0] act;
        logic [5+CW:0] want;
        logic [32:0]   res;
        if (mon_en) begin
            act  = {ld, sh, carry_clr, carry_en, busy, done, bit_cnt};
            want = exp_vec.exists(cyc) ? exp_vec[cyc] : '0;
            checks++;
            if (act !== want) begin
                errors++;
                $display("FAIL ctrl_outputs cyc=%0d got=%b want=%b", cyc, act, want);
            end
            if (done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d got=done want=no_done", cyc);
                end else begin
                    res = sb_q.pop_front();
                    if ({cf, rs} !== res) begin
                        errors++;
                        $display("FAIL sum cyc=%0d got=%h want=%h", cyc, {cf, rs}, res);
                    end
                end
            end
        end
    end

    // Expected profile of one operation whose load cycle is e, truncated after cycle last.
    function automatic void expect_op(input int e, input int last);
        logic [5+CW:0] v;
        for (int iv = e; iv <= e + W + 1 && iv <= last; iv++) begin
            if (iv == e)          v = {6'b101010, CW'(0)};
            else if (iv <= e + W) v = {6'b010110, CW'(iv - e - 1)};
            else                  v = {6'b000001, CW'(0)};
            exp_vec[iv] = v;
        end
    endfunction

    // kind: 0 normal, 1 abort in LOAD, 2 abort at shift bit k, 3 reset at shift bit k,
    //       4 start and abort together in IDLE (completes normally)
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int kind,
                          input int k, input bit noise);
        int e;
        int last;
        @(negedge clk);
        opa   = a;
        opb   = b;
        start = 1'b1;
        abort = (kind == 4);
        e     = cyc + 1;
        case (kind)
            1:       last = e;
            2, 3:    last = e + 1 + k;
            default: last = e + W + 1;
        endcase
        expect_op(e, last);
        if (kind == 0 || kind == 4) sb_q.push_back({1'b0, a} + {1'b0, b});
        @(negedge clk);
        start = 1'b0;
        abort = (kind == 1);
        if (kind == 1) begin
            @(negedge clk);
            abort = 1'b0;
        end else begin
            for (int iv = e + 1; iv <= e + W + 2; iv++) begin
                @(negedge clk);
                if (kind == 2 && iv == e + 1 + k) begin
                    abort = 1'b1;
                    start = 1'b0;
                end else if (kind == 3 && iv == e + 1 + k) begin
                    reset = 1'b1;
                    start = 1'b0;
                end else if ((kind == 2 || kind == 3) && iv == e + 2 + k) begin
                    abort = 1'b0;
                    reset = 1'b0;
                    break;
                end else begin
                    start = (noise && iv <= e + W + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                end
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_start(input logic [31:0] a, input logic [31:0] b);
        int e0;
        int c0;
        @(negedge clk);
        opa   = a;
        opb   = b;
        start = 1'b1;
        c0    = cyc;
        e0    = cyc + 1;
        for (int n = 0; n < 3; n++) begin
            expect_op(e0 + n * PERIOD, e0 + n * PERIOD + W + 1);
            sb_q.push_back({1'b0, a} + {1'b0, b});
        end
        repeat (e0 + 2 * PERIOD + 1 - c0) @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        opa   = '0;
        opb   = '0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        run_op(32'h9292_9292, 32'h0000_006E, 0, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 1'b1);
        run_op($urandom, $urandom, 2, 10, 1'b1);
        run_op($urandom, $urandom, 0, 0, 1'b0);
        run_op($urandom, $urandom, 3, 20, 1'b1);
        run_op($urandom, $urandom, 4, 0, 1'b0);
        run_op($urandom, $urandom, 1, 0, 1'b0);
        run_op($urandom, $urandom, 2, 0, 1'b0);
        run_op($urandom, $urandom, 2, W - 1, 1'b1);
        hold_start($urandom, $urandom);
        for (int i = 0; i < 10; i++) begin
            run_op($urandom, $urandom, int'($urandom_range(0, 4)),
                   int'($urandom_range(0, W - 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done got=%0d_pending want=0_pending", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencing controller for the bit-serial add datapath built from two 32-bit shift registers (operands A and B) and a carry flip-flop feeding a 1-bit full adder.
- Accepts a start request and issues a one-cycle parallel-load strobe to both registers.
- Then issues exactly WIDTH shift strobes while enabling the carry flop, and signals completion with a one-cycle done pulse.
- Owns no operand data; it only sequences the datapath and reports progress.

Parameters:
WIDTH, 32, operand width = number of shift cycles per operation (>= 2)
CNT_W, $clog2(WIDTH), localparam; width of the bit counter

Ports:
clk        input   1      system clock, all state changes on rising edge
reset      input   1      synchronous, active-high; clears all state on the next rising edge
start      input   1      request to begin an add; sampled only in IDLE
abort      input   1      cancel an in-progress operation; sampled in LOAD and SHIFT
ld         output  1      parallel-load strobe to both operand shift registers
sh         output  1      shift strobe to both operand registers and the result register
carry_clr  output  1      synchronous clear of the carry flop
carry_en   output  1      carry flop capture enable
busy       output  1      high in LOAD and SHIFT
done       output  1      one-cycle completion pulse
bit_cnt    output  CNT_W  index of the bit being processed in the current SHIFT cycle

Behaviour:
- Moore FSM, states IDLE, LOAD, SHIFT, DONE. All outputs are decoded from registered state and counter; no combinational input-to-output path.
- Reset (reset=1 at a rising edge):
  - state=IDLE, bit_cnt=0.
  - ld=sh=carry_clr=carry_en=busy=done=0.
  - Reset dominates start and abort.
  - Reset mid-operation aborts immediately, with no done pulse.
- IDLE:
  - All strobes 0, busy=0, bit_cnt held at 0.
  - start=1 -> LOAD; otherwise stay.
- LOAD, exactly 1 cycle:
  - ld=1, carry_clr=1, busy=1, bit_cnt=0.
  - abort=1 -> IDLE; else -> SHIFT.
- SHIFT, exactly WIDTH cycles:
  - sh=1, carry_en=1, busy=1.
  - bit_cnt reads 0 in the first SHIFT cycle and increments by 1 each cycle.
  - When bit_cnt==WIDTH-1 -> DONE, and bit_cnt returns to 0.
  - abort=1 in any SHIFT cycle -> IDLE next edge, bit_cnt=0, no done pulse. The strobe in the abort cycle itself is still asserted.
- DONE, exactly 1 cycle:
  - done=1, busy=0, all strobes 0 -> IDLE unconditionally.
  - start in DONE is ignored; a new request must be (re)asserted in IDLE.
- Latency: start sampled at edge t gives:
  - ld high during cycle t+1;
  - sh high during cycles t+2 .. t+WIDTH+1;
  - done high during cycle t+WIDTH+2.
  - Back-to-back operations with start held high: next ld at t+WIDTH+4, because IDLE occupies one cycle.
- start while busy is ignored; it is not queued.
- ld and sh are mutually exclusive in every cycle. carry_clr is asserted only together with ld.
- bit_cnt wrap: counter never exceeds WIDTH-1. Overflow is unreachable; an illegal state encoding recovers to IDLE on the next edge.
- Simultaneous start and abort in IDLE: start wins, since abort is ignored in IDLE.

Decomposition:
- Shared package serial_add_pkg holds:
  - the state enum (IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3);
  - the default WIDTH constant.
- One natural sub-module: bit_counter, a CNT_W-bit up-counter with synchronous clear, enable, and a terminal-count flag at WIDTH-1. It is reused by the datapath testbench checker.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, start=0 -> all outputs 0, bit_cnt=0 for 10 cycles.
- Nominal run, WIDTH=32: start pulse at edge t ->
  - ld=1 only at t+1;
  - sh=1 for exactly 32 cycles t+2..t+33, with bit_cnt 0..31;
  - done=1 only at t+34;
  - busy=1 t+1..t+33.
- End-to-end with datapath: A=32'h92929292, B=32'h0000_006E -> result register holds 32'h92929300 after done. Also run A=32'hFFFFFFFF, B=1 -> result 0, final carry=1.
- Abort at bit_cnt=10 -> IDLE next edge, no done pulse; then a fresh start completes normally in 34 cycles.
- Reset asserted while bit_cnt=20 -> next edge all outputs 0, no done pulse; start asserted during busy never extends or restarts the run.
- start held high continuously -> operations repeat with a period of 35 cycles, done pulses exactly one cycle wide, and ld never coincides with sh.
